// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: one-cycle arithmetic/logic ops plus an iterative one-bit-per-cycle
// shifter, both feeding a single valid/ready output register with result and flags.
module alu_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zf,
    output logic            cf,
    output logic            vf,
    output logic            sf,
    output logic            busy
);

    // state | meaning
    // IDLE  | ready for a new op; one-cycle ops complete from here
    // SHIFT | shifting one bit per cycle, counter counts shamt down to 0
    // HOLD  | shift finished, waiting for the output slot to free up

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] sh_reg;
    logic [4:0]      cnt;
    logic            sh_left;
    logic            sh_arith;

    logic            slot_free;
    logic            accept;
    logic            is_sub;
    logic            is_shift;
    logic [4:0]      shamt;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] comb_res;
    logic            comb_cf;
    logic            comb_vf;
    logic [XLEN-1:0] shift_next;

    logic            load_en;
    logic            start_shift;
    logic [XLEN-1:0] load_val;
    logic            load_cf;
    logic            load_vf;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !rst && !flush && (state == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != S_IDLE);
    assign shamt     = op_b[4:0];
    assign is_sub    = (alu_sel == ALU_SUB);
    assign is_shift  = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);

    // SUB reuses the adder as a + ~b + 1, so carry-out high means no borrow
    always_comb begin
        b_eff    = is_sub ? ~op_b : op_b;
        sum      = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
        comb_res = '0;
        comb_cf  = 1'b0;
        comb_vf  = 1'b0;
        case (alu_sel)
            ALU_ADD, ALU_SUB: begin
                comb_res = sum[XLEN-1:0];
                comb_cf  = sum[XLEN];
                comb_vf  = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: comb_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  comb_res = op_a ^ op_b;
            ALU_OR:   comb_res = op_a | op_b;
            ALU_AND:  comb_res = op_a & op_b;
            ALU_PASS: comb_res = op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: comb_res = op_a;
            default:  comb_res = '0;
        endcase
    end

    always_comb begin
        if (sh_left) begin
            shift_next = {sh_reg[XLEN-2:0], 1'b0};
        end else begin
            shift_next = {sh_arith & sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
        end
    end

    // Selects what, if anything, lands in the output register this edge
    always_comb begin
        load_en     = 1'b0;
        start_shift = 1'b0;
        load_val    = comb_res;
        load_cf     = comb_cf;
        load_vf     = comb_vf;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        start_shift = 1'b1;
                    end else begin
                        load_en = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if ((cnt == 5'd1) && slot_free) begin
                    load_en  = 1'b1;
                    load_val = shift_next;
                    load_cf  = 1'b0;
                    load_vf  = 1'b0;
                end
            end
            S_HOLD: begin
                if (slot_free) begin
                    load_en  = 1'b1;
                    load_val = sh_reg;
                    load_cf  = 1'b0;
                    load_vf  = 1'b0;
                end
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sh_reg   <= '0;
            cnt      <= 5'd0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_shift) begin
                        sh_reg   <= op_a;
                        cnt      <= shamt;
                        sh_left  <= (alu_sel == ALU_SLL);
                        sh_arith <= (alu_sel == ALU_SRA);
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sh_reg <= shift_next;
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= slot_free ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            vf        <= 1'b0;
            sf        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            result    <= load_val;
            zf        <= (load_val == '0);
            sf        <= load_val[XLEN-1];
            cf        <= load_cf;
            vf        <= load_vf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: transaction-level reference model compared every cycle,
// directed literal checks, then randomized traffic with backpressure, flush and reset.
module tb_alu_exec_stage;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_sel = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zf, cf, vf, sf, busy;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    alu_exec_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_shift_op(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

    // Returns {zf, cf, vf, sf, result} from plain integer arithmetic
    function automatic logic [35:0] ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c, v;
        longint sa, sb, sd;
        r = 32'd0; c = 1'b0; v = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (sel)
            ALU_ADD: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
                sd = sa + sb;
                v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            ALU_SUB: begin
                r = a - b;
                c = (a >= b);
                sd = sa - sb;
                v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_PASS: r = b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            default:  r = 32'd0;
        endcase
        return {(r == 32'd0), c, v, r[31], r};
    endfunction

    // Model: output slot, plus a pending shift result with cycles still to run
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [35:0] m_out = '0;
    logic [35:0] m_pend = '0;

    always @(posedge clk) begin : model
        bit free, acc;
        if (rst) begin
            m_valid = 1'b0; m_busy = 1'b0; m_left = 0; m_out = '0;
        end else if (flush) begin
            m_valid = 1'b0; m_busy = 1'b0; m_left = 0;
        end else begin
            free = !m_valid || out_ready;
            acc  = in_valid && !m_busy && free;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (acc) begin
                if (is_shift_op(alu_sel) && (op_b[4:0] != 5'd0)) begin
                    m_busy = 1'b1;
                    m_left = int'(op_b[4:0]);
                    m_pend = ref_alu(alu_sel, op_a, op_b);
                end else begin
                    m_out = ref_alu(alu_sel, op_a, op_b);
                    m_valid = 1'b1;
                end
            end else if (m_busy) begin
                if (m_left > 1) begin
                    m_left--;
                end else begin
                    m_left = 0;
                    if (free) begin
                        m_out = m_pend; m_valid = 1'b1; m_busy = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, !rst && !flush && !m_busy && (!m_valid || out_ready));
            check("out_valid", out_valid, m_valid);
            check("busy", busy, m_busy);
            if (m_valid) check("result_flags", {zf, cf, vf, sf, result}, m_out);
        end
    end

    // Issues one op with out_ready as currently set; lat counts edges from the handshake cycle
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [35:0] got, output int lat, output int rdy_hi);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready 0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; rdy_hi = 0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready && !out_valid) rdy_hi++;
        end while (!out_valid && lat < 100);
        got = {zf, cf, vf, sf, result};
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [35:0] got;
        int lat, rdy_hi, seen;

        rst = 1'b1; in_valid = 1'b1; alu_sel = ALU_ADD; op_a = 32'd1; op_b = 32'd2; out_ready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_result_flags", {zf, cf, vf, sf, result}, 36'd0);
            check("rst_busy", busy, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("first_op", {out_valid, zf, cf, vf, sf, result}, {1'b1, 4'b0000, 32'd3});

        // got = {zf, cf, vf, sf, result}
        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, got, lat, rdy_hi);
        check("add_ovf", got, {4'b0011, 32'h8000_0000});
        check("add_lat", lat, 1);
        do_op(ALU_SUB, 32'd5, 32'd5, got, lat, rdy_hi);
        check("sub_zero", got, {4'b1100, 32'h0000_0000});
        do_op(ALU_SUB, 32'd0, 32'd1, got, lat, rdy_hi);
        check("sub_borrow", got, {4'b0001, 32'hFFFF_FFFF});
        do_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, got, lat, rdy_hi);
        check("slt", got, {4'b0000, 32'd1});
        do_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, got, lat, rdy_hi);
        check("sltu", got, {4'b1000, 32'd0});
        do_op(ALU_PASS, 32'hDEAD_BEEF, 32'h1234_5000, got, lat, rdy_hi);
        check("pass", got, {4'b0000, 32'h1234_5000});
        do_op(4'hF, 32'hDEAD_BEEF, 32'h1234_5000, got, lat, rdy_hi);
        check("undef_op", got, {4'b1000, 32'd0});

        // Shift results appear shamt edges after the accepting edge
        do_op(ALU_SRA, 32'h8000_0000, 32'd31, got, lat, rdy_hi);
        check("sra31", got, {4'b0001, 32'hFFFF_FFFF});
        check("sra31_lat", lat, 32);
        check("sra31_ready_low", rdy_hi, 0);
        do_op(ALU_SLL, 32'd1, 32'd0, got, lat, rdy_hi);
        check("sll0", got, {4'b0000, 32'd1});
        check("sll0_lat", lat, 1);
        do_op(ALU_SRL, 32'h8000_0000, 32'd4, got, lat, rdy_hi);
        check("srl4", got, {4'b0000, 32'h0800_0000});
        check("srl4_lat", lat, 5);

        // Backpressure: held result stays put and blocks new work
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op(ALU_ADD, 32'd1, 32'd2, got, lat, rdy_hi);
        check("bp_add", got, {4'b0000, 32'd3});
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_result", {out_valid, result}, {1'b1, 32'd3});
            check("bp_hold_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; alu_sel = ALU_SLL; op_a = 32'd5; op_b = 32'd2;
        repeat (2) begin
            @(negedge clk);
            check("bp_shift_blocked", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_shift_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_shift_busy", {busy, out_valid}, {1'b1, 1'b0});
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_shift_result", result, 32'd20);
        check("bp_shift_lat", lat, 3);

        // Flush at cycle 10 of a 20-cycle shift: nothing must ever come out
        @(posedge clk); #1;
        in_valid = 1'b1; alu_sel = ALU_SRL; op_a = 32'hFFFF_0000; op_b = 32'd20;
        @(negedge clk);
        check("flush_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {busy, out_valid}, 2'b00);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // Randomized traffic against the model
        repeat (1500) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_sel   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            op_a      = rnd_word();
            op_b      = rnd_word();
            if ($urandom_range(0, 1) == 0) op_b[4:0] = 5'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 150) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
